// File: rtl/rdm_llr_combiner.sv
// HARQ soft-combine stage: saturating read-modify-write of LANES LLRs per beat
// into the combine buffer, with S2/W2 forwarding and optional Ncb region pre-clear.
module rdm_llr_combiner #(
    parameter int LLR_W  = 6,
    parameter int ACC_W  = 8,
    parameter int LANES  = 16,
    parameter int ADDR_W = 12
) (
    input  logic                   i_core_clk,
    input  logic                   i_rx_rstn,
    input  logic                   i_Combine_process_request,
    input  logic                   i_First_Transmission,
    input  logic [15:0]            i_Current_Combine_Ncb_Size,
    input  logic                   i_RDM_Valid,
    input  logic [LANES*LLR_W-1:0] i_RDM_Data,
    input  logic [15:0]            i_RDM_Ncb_Address,
    input  logic                   i_RDM_Last,
    output logic                   o_RDM_Data_Request,
    output logic                   o_Combine_Rd_En,
    output logic [ADDR_W-1:0]      o_Combine_Rd_Addr,
    input  logic [LANES*ACC_W-1:0] i_Combine_Rd_Data,
    output logic                   o_Combine_Wr_En,
    output logic [ADDR_W-1:0]      o_Combine_Wr_Addr,
    output logic [LANES*ACC_W-1:0] o_Combine_Wr_Data,
    output logic                   o_Combine_Done,
    output logic                   o_Addr_Error
);
    localparam int LG_LANES = $clog2(LANES);
    localparam int CNT_W    = 17;
    localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       nw_q, nw_d;
    logic [CNT_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic                   addr_err_q, addr_err_d;
    logic                   s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0]      s1_addr_q, s1_addr_d;
    logic [LANES*LLR_W-1:0] s1_llr_q, s1_llr_d;
    logic                   s2_vld_q, s2_vld_d;
    logic [ADDR_W-1:0]      s2_addr_q, s2_addr_d;
    logic [LANES*ACC_W-1:0] s2_data_q, s2_data_d;
    logic                   w2_vld_q, w2_vld_d;
    logic [ADDR_W-1:0]      w2_addr_q, w2_addr_d;
    logic [LANES*ACC_W-1:0] w2_data_q, w2_data_d;
    logic [LANES*ACC_W-1:0] old_word;
    logic [CNT_W-1:0]       ncb_round;
    logic                   accept, in_range, clr_wr, clr_last;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] old_v,
                                                 input logic [LLR_W-1:0] llr_v);
        logic signed [ACC_W:0] sum_v;
        sum_v = $signed({old_v[ACC_W-1], old_v})
              + $signed({{(ACC_W+1-LLR_W){llr_v[LLR_W-1]}}, llr_v});
        if (sum_v > SAT_MAX) return SAT_MAX[ACC_W-1:0];
        if (sum_v < SAT_MIN) return SAT_MIN[ACC_W-1:0];
        return sum_v[ACC_W-1:0];
    endfunction

    always_comb begin
        accept    = (state_q == RUN) && i_RDM_Valid;
        in_range  = {1'b0, i_RDM_Ncb_Address} < nw_q;
        clr_wr    = (state_q == CLEAR) && (clr_cnt_q < nw_q);
        clr_last  = (state_q == CLEAR) &&
                    ((nw_q == '0) || (clr_cnt_q == nw_q - CNT_W'(1)));
        ncb_round = {1'b0, i_Current_Combine_Ncb_Size} + CNT_W'(LANES-1);
    end

    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_Combine_process_request)
                         state_d = i_First_Transmission ? CLEAR : RUN;
            CLEAR:   if (clr_last) state_d = RUN;
            RUN:     if (accept && i_RDM_Last) state_d = DRAIN;
            DRAIN:   if (!s1_vld_q && !s2_vld_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_RDM_Data_Request = (state_q == RUN);
        o_Combine_Done     = (state_q == DONE);
        o_Addr_Error       = addr_err_q;
        o_Combine_Rd_En    = accept && in_range;
        o_Combine_Rd_Addr  = o_Combine_Rd_En ? i_RDM_Ncb_Address[ADDR_W-1:0] : '0;
        if (state_q == CLEAR) begin
            o_Combine_Wr_En   = clr_wr;
            o_Combine_Wr_Addr = clr_wr ? clr_cnt_q[ADDR_W-1:0] : '0;
            o_Combine_Wr_Data = '0;
        end else begin
            o_Combine_Wr_En   = s2_vld_q;
            o_Combine_Wr_Addr = s2_vld_q ? s2_addr_q : '0;
            o_Combine_Wr_Data = s2_vld_q ? s2_data_q : '0;
        end
    end

    always_comb begin
        nw_d       = nw_q;
        clr_cnt_d  = clr_cnt_q;
        addr_err_d = addr_err_q;
        if ((state_q == IDLE) && i_Combine_process_request) begin
            nw_d       = ncb_round >> LG_LANES;
            clr_cnt_d  = '0;
            addr_err_d = 1'b0;
        end
        if (state_q == CLEAR) clr_cnt_d = clr_cnt_q + CNT_W'(1);
        if (accept && !in_range) addr_err_d = 1'b1;

        s1_vld_d  = accept && in_range;
        s1_addr_d = i_RDM_Ncb_Address[ADDR_W-1:0];
        s1_llr_d  = i_RDM_Data;

        // S2 holds the word being written now; W2 the one written last cycle,
        // which a read-first buffer returned stale to the beat now in S1.
        old_word = i_Combine_Rd_Data;
        if (s2_vld_q && (s2_addr_q == s1_addr_q))      old_word = s2_data_q;
        else if (w2_vld_q && (w2_addr_q == s1_addr_q)) old_word = w2_data_q;

        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;
        s2_data_d = '0;
        for (int unsigned k = 0; k < LANES; k++)
            s2_data_d[k*ACC_W +: ACC_W] = sat_add(old_word[k*ACC_W +: ACC_W],
                                                  s1_llr_q[k*LLR_W +: LLR_W]);

        w2_vld_d  = o_Combine_Wr_En && !clr_last;
        w2_addr_d = o_Combine_Wr_Addr;
        w2_data_d = o_Combine_Wr_Data;
    end

    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) begin
            nw_q       <= '0;
            clr_cnt_q  <= '0;
            addr_err_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_llr_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            w2_vld_q   <= 1'b0;
            w2_addr_q  <= '0;
            w2_data_q  <= '0;
        end else begin
            nw_q       <= nw_d;
            clr_cnt_q  <= clr_cnt_d;
            addr_err_q <= addr_err_d;
            s1_vld_q   <= s1_vld_d;
            s1_addr_q  <= s1_addr_d;
            s1_llr_q   <= s1_llr_d;
            s2_vld_q   <= s2_vld_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
            w2_vld_q   <= w2_vld_d;
            w2_addr_q  <= w2_addr_d;
            w2_data_q  <= w2_data_d;
        end
    end

endmodule

// File: doc/rdm_llr_combiner.md
Name: rdm_llr_combiner

Overview:
- Stage directly downstream of the rate-dematching FSM.
- Accepts 16 soft LLRs per beat, already mapped to circular-buffer (Ncb) word positions, and accumulates them with saturation into the HARQ combine buffer.
- Operation per word is a pipelined read-modify-write with hazard forwarding.
- On a first transmission the block zero-clears the Ncb region before accumulating, so repeated positions (E > Ncb) still combine.

Parameters:
- LLR_W, 6, input LLR width (signed two's complement).
- ACC_W, 8, combine-buffer soft-value width (signed).
- LANES, 16, LLRs per beat.
- ADDR_W, 12, combine-buffer word address width.

Ports:
- i_core_clk  in  1  core clock.
- i_rx_rstn  in  1  synchronous active-low reset.
- i_Combine_process_request  in  1  start pulse; sampled only in IDLE.
- i_First_Transmission  in  1  sampled with start; 1 = clear region first.
- i_Current_Combine_Ncb_Size  in  16  Ncb in LLRs; sampled with start.
- i_RDM_Valid  in  1  input beat valid.
- i_RDM_Data  in  LANES*LLR_W  lane k at bits [k*LLR_W +: LLR_W].
- i_RDM_Ncb_Address  in  16  word index within Ncb (units of LANES).
- i_RDM_Last  in  1  marks final beat of the code block.
- o_RDM_Data_Request  out  1  ready; a beat transfers when Valid & Request.
- o_Combine_Rd_En  out  1  buffer read strobe.
- o_Combine_Rd_Addr  out  ADDR_W  read address.
- i_Combine_Rd_Data  in  LANES*ACC_W  read data, 1-cycle latency, read-first on same-address collision.
- o_Combine_Wr_En  out  1  buffer write strobe.
- o_Combine_Wr_Addr  out  ADDR_W  write address.
- o_Combine_Wr_Data  out  LANES*ACC_W  write data.
- o_Combine_Done  out  1  one-cycle pulse at completion.
- o_Addr_Error  out  1  sticky; set on any out-of-range beat; cleared by reset or next start.

Behaviour:
- Reset: all outputs 0. FSM enters IDLE. Pipeline valids and forward registers are cleared.
- NW = ceil(Ncb/LANES), computed at start as (Ncb + LANES-1) >> log2(LANES). Example: Ncb=98 gives NW=7.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
  - IDLE -> CLEAR on start when First_Transmission=1.
  - IDLE -> RUN on start when First_Transmission=0.
  - Start in any other state is ignored.
- CLEAR:
  - One write per cycle, addr 0..NW-1, data all zero, no reads.
  - After the NW-1 write, go to RUN next cycle.
  - Ncb=0 gives NW=0: CLEAR lasts 1 cycle with no writes.
- RUN:
  - o_RDM_Data_Request=1.
  - A transferred beat with Last=1 moves the FSM to DRAIN. Request drops the cycle after that transfer.
- DRAIN: Request=0. Hold until the pipeline is empty, then go to DONE.
- DONE: o_Combine_Done=1 for one cycle, then IDLE.
- Pipeline, for a beat accepted at cycle t:
  - t (S0): Rd_En=1, Rd_Addr=address[ADDR_W-1:0].
  - t+1 (S1): compute the per-lane sum, then register it.
  - t+2 (S2): Wr_En=1 with the same address.
  - Throughput: 1 beat/cycle; no backpressure from the buffer.
- Per-lane sum:
  - sum = old + sign_extend(llr), computed at ACC_W+1 bits.
  - Clamp symmetrically to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)], i.e. ±127 for ACC_W=8.
- Forwarding: choose the S1 "old" value with this priority:
  1. If the S2 stage is valid with the same address, use the S2 write data.
  2. Else if the previous-cycle write register (W2, the last written word and its address) is valid with the same address, use W2 data.
  3. Else use i_Combine_Rd_Data.
  - W2 covers the read-first collision.
  - CLEAR writes also load W2; W2 valid clears when CLEAR ends. There is no overlap, since RUN starts only after CLEAR completes.
- Out-of-range beat (address >= NW):
  - Accepted, but no read and no write occur.
  - Sets o_Addr_Error.
  - Still counts for Last.
- Reset mid-operation: everything aborts next edge. Buffer contents are undefined for that block.

Test Plan:
- Start, First=1, Ncb=98 -> 7 writes addr 0..6, data 0, one per cycle. Request rises the cycle after the addr-6 write.
- RUN, single beat at addr 2, all lanes +5, Last=1 -> Rd_En at t, Wr addr 2 all lanes 5 at t+2. Done pulses when the pipeline is empty; Request is 0 after the transfer.
- After clear, 6 back-to-back beats at addr 3, all lanes +31 -> writes of 31, 62, 93, 124, 127, 127 on consecutive cycles (S2 forwarding).
- Beats at addr 4, 5, 4 alternating, lane value -32, five beats at addr 4 -> addr 4 writes -32, -64, -96, -127, -127 (W2 forwarding on gap-1 reuse).
- Ncb=98, beat at addr 7 -> no Rd_En/Wr_En, o_Addr_Error=1 and stays 1. It clears on the next start.
- Reset asserted during RUN with a beat in S1 -> next edge: all outputs 0, no write; a new start then behaves as from a fresh reset.
